// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory responder: default geometry,
// wait-counter width and the state/access encodings used by the FSM.
package cpu_mem_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 24;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  // Classification of a sampled request; ACC_BAD covers both the
  // read+write collision and an address beyond the implemented depth.
  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_READ,
    ACC_WRITE,
    ACC_BAD
  } access_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter. The zero flag is high when the count reaches
// zero on the coming edge, so the FSM can leave WAIT on that same edge.
module mem_wait_counter
  import cpu_mem_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count <= CNT_W'(1));

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the CPU datapath: latches one MemRead/MemWrite
// request, inserts WAIT_CYCLES wait states, then pulses Ready or Error for
// one cycle. Storage is a single-port synchronous RAM without reset.
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Ready,
  output logic              Error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_state_t        state;
  access_t           req_type;
  access_t           resp_type;
  access_t           lat_type;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [IDX_W-1:0]  ram_idx;
  logic [DATA_W-1:0] ram_q;
  logic              cnt_load;
  logic              cnt_zero;
  logic              enter_resp;
  logic              ram_re;
  logic              ram_we;
  logic              ready_q;
  logic              error_q;
  logic              read_q;

  logic [DATA_W-1:0] mem [DEPTH];

  mem_wait_counter u_wait_counter (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (cnt_load),
    .load_value (CNT_W'(WAIT_CYCLES)),
    .zero       (cnt_zero)
  );

  // Classify the live request; collisions and out-of-range addresses are rejected up front.
  always_comb begin
    req_type = ACC_NONE;
    if (MemRead && MemWrite) begin
      req_type = ACC_BAD;
    end else if (MemRead || MemWrite) begin
      if (32'(Address) >= 32'(DEPTH)) begin
        req_type = ACC_BAD;
      end else if (MemRead) begin
        req_type = ACC_READ;
      end else begin
        req_type = ACC_WRITE;
      end
    end
  end

  // RAM port control: with no wait states the read happens on the sampling edge using the live address.
  always_comb begin
    enter_resp = 1'b0;
    if (state == IDLE) begin
      enter_resp = (req_type != ACC_NONE) && (WAIT_CYCLES == 0);
    end else if (state == WAIT) begin
      enter_resp = cnt_zero;
    end
    resp_type = (state == IDLE) ? req_type : lat_type;
    ram_addr  = (state == IDLE) ? Address : lat_addr;
    ram_idx   = IDX_W'(ram_addr);
    cnt_load  = (state == IDLE) && (req_type != ACC_NONE);
    ram_re    = !Reset && enter_resp && (resp_type == ACC_READ);
    ram_we    = !Reset && (state == RESP) && (lat_type == ACC_WRITE);
  end

  // Transaction FSM with registered completion pulses; reset aborts any pending access.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      lat_type <= ACC_NONE;
      lat_addr <= '0;
      lat_data <= '0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
      read_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      read_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_type != ACC_NONE) begin
            lat_type <= req_type;
            lat_addr <= Address;
            lat_data <= WriteData;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_zero) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (enter_resp) begin
        ready_q <= (resp_type != ACC_BAD);
        error_q <= (resp_type == ACC_BAD);
        read_q  <= (resp_type == ACC_READ);
      end
    end
  end

  // Single-port storage: the write lands on the edge leaving RESP, the read on the edge entering it.
  always_ff @(posedge Clock) begin
    if (ram_we) begin
      mem[ram_idx] <= lat_data;
    end
    if (ram_re) begin
      ram_q <= mem[ram_idx];
    end
  end

  assign Ready    = ready_q;
  assign Error    = error_q;
  assign ReadData = read_q ? ram_q : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instance a uses the defaults
// (two wait states, 256 words), instance b has no wait states and 128 words.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;

  logic        a_rd;
  logic        a_wr;
  logic [7:0]  a_addr;
  logic [23:0] a_wdata;
  logic [23:0] a_rdata;
  logic        a_ready;
  logic        a_error;

  logic        b_rd;
  logic        b_wr;
  logic [7:0]  b_addr;
  logic [23:0] b_wdata;
  logic [23:0] b_rdata;
  logic        b_ready;
  logic        b_error;

  int checks = 0;
  int errors = 0;

  data_mem_responder dut_a (
    .Clock     (clk),
    .Reset     (reset),
    .MemRead   (a_rd),
    .MemWrite  (a_wr),
    .Address   (a_addr),
    .WriteData (a_wdata),
    .ReadData  (a_rdata),
    .Ready     (a_ready),
    .Error     (a_error)
  );

  data_mem_responder #(
    .DEPTH       (128),
    .WAIT_CYCLES (0)
  ) dut_b (
    .Clock     (clk),
    .Reset     (reset),
    .MemRead   (b_rd),
    .MemWrite  (b_wr),
    .Address   (b_addr),
    .WriteData (b_wdata),
    .ReadData  (b_rdata),
    .Ready     (b_ready),
    .Error     (b_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input int sel, input logic rd, input logic wr,
                                input logic [7:0] addr, input logic [23:0] wdata);
    if (sel == 0) begin
      a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata;
    end else begin
      b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wdata;
    end
  endtask

  task automatic sample_outputs(input int sel, output logic r, output logic e,
                                output logic [23:0] d);
    if (sel == 0) begin
      r = a_ready; e = a_error; d = a_rdata;
    end else begin
      r = b_ready; e = b_error; d = b_rdata;
    end
  endtask

  // One request held for a single sampling edge, then the completion pulse is awaited.
  task automatic expect_txn(input string tag, input int sel, input logic rd, input logic wr,
                            input logic [7:0] addr, input logic [23:0] wdata, input bit churn,
                            input int exp_lat, input logic exp_ready, input logic exp_error,
                            input logic [23:0] exp_data);
    int          lat;
    logic        r;
    logic        e;
    logic [23:0] d;
    logic        r_now;
    logic        e_now;
    logic [23:0] d_now;
    lat = -1; r = 1'b0; e = 1'b0; d = '0;
    @(negedge clk);
    apply_stimulus(sel, rd, wr, addr, wdata);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (churn) begin
        apply_stimulus(sel, 1'b0, 1'b0, addr ^ 8'(k + 1), wdata ^ 24'(32'h5A5A5A * (k + 1)));
      end else begin
        apply_stimulus(sel, 1'b0, 1'b0, 8'h00, 24'h000000);
      end
      sample_outputs(sel, r_now, e_now, d_now);
      if (r_now || e_now) begin
        lat = k + 1; r = r_now; e = e_now; d = d_now;
        break;
      end
    end
    apply_stimulus(sel, 1'b0, 1'b0, 8'h00, 24'h000000);
    check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_output({tag, "_flags"}, {30'b0, r, e}, {30'b0, exp_ready, exp_error});
    check_output({tag, "_rdata"}, {8'b0, d}, {8'b0, exp_data});
    @(negedge clk);
    sample_outputs(sel, r_now, e_now, d_now);
    check_output({tag, "_pulse_end"}, {6'b0, r_now, e_now, d_now}, 32'h0);
  endtask

  initial begin
    logic        seen;
    logic        exp_r;
    logic [23:0] exp_d;

    reset = 1'b1;
    apply_stimulus(0, 1'b0, 1'b0, 8'h00, 24'h000000);
    apply_stimulus(1, 1'b0, 1'b0, 8'h00, 24'h000000);
    repeat (3) @(negedge clk);
    check_output("rst_a_ready", {31'b0, a_ready}, 32'h0);
    check_output("rst_a_error", {31'b0, a_error}, 32'h0);
    check_output("rst_a_rdata", {8'b0, a_rdata}, 32'h0);
    check_output("rst_b_ready", {31'b0, b_ready}, 32'h0);
    check_output("rst_b_error", {31'b0, b_error}, 32'h0);
    check_output("rst_b_rdata", {8'b0, b_rdata}, 32'h0);
    reset = 1'b0;
    $display("[TB] reset released");

    // Write then read with two wait states.
    expect_txn("a_wr10", 0, 1'b0, 1'b1, 8'h10, 24'hABCDEF, 1'b0, 3, 1'b1, 1'b0, 24'h000000);
    expect_txn("a_rd10", 0, 1'b1, 1'b0, 8'h10, 24'h000000, 1'b0, 3, 1'b1, 1'b0, 24'hABCDEF);

    // Read and write together must be rejected and leave the word alone.
    expect_txn("a_wr05", 0, 1'b0, 1'b1, 8'h05, 24'h0F0F0F, 1'b0, 3, 1'b1, 1'b0, 24'h000000);
    expect_txn("a_both05", 0, 1'b1, 1'b1, 8'h05, 24'h777777, 1'b0, 3, 1'b0, 1'b1, 24'h000000);
    expect_txn("a_rd05", 0, 1'b1, 1'b0, 8'h05, 24'h000000, 1'b0, 3, 1'b1, 1'b0, 24'h0F0F0F);

    // Reset on the first wait cycle aborts the pending write.
    expect_txn("a_wr20", 0, 1'b0, 1'b1, 8'h20, 24'h654321, 1'b0, 3, 1'b1, 1'b0, 24'h000000);
    @(negedge clk);
    apply_stimulus(0, 1'b0, 1'b1, 8'h20, 24'h123456);
    @(negedge clk);
    apply_stimulus(0, 1'b0, 1'b0, 8'h00, 24'h000000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_ready || a_error) seen = 1'b1;
    end
    check_output("a_rst_wait_no_pulse", {31'b0, seen}, 32'h0);
    expect_txn("a_rd20", 0, 1'b1, 1'b0, 8'h20, 24'h000000, 1'b0, 3, 1'b1, 1'b0, 24'h654321);

    // Address and data churn while waiting must not reach the array.
    expect_txn("a_wr31", 0, 1'b0, 1'b1, 8'h31, 24'h313131, 1'b0, 3, 1'b1, 1'b0, 24'h000000);
    expect_txn("a_churn30", 0, 1'b0, 1'b1, 8'h30, 24'hC0FFEE, 1'b1, 3, 1'b1, 1'b0, 24'h000000);
    expect_txn("a_rd30", 0, 1'b1, 1'b0, 8'h30, 24'h000000, 1'b0, 3, 1'b1, 1'b0, 24'hC0FFEE);
    expect_txn("a_rd31", 0, 1'b1, 1'b0, 8'h31, 24'h000000, 1'b0, 3, 1'b1, 1'b0, 24'h313131);

    // Zero wait states: preload, then a held read completes every second cycle.
    expect_txn("b_wr00", 1, 1'b0, 1'b1, 8'h00, 24'hA0A0A0, 1'b0, 1, 1'b1, 1'b0, 24'h000000);
    expect_txn("b_wr01", 1, 1'b0, 1'b1, 8'h01, 24'hB1B1B1, 1'b0, 1, 1'b1, 1'b0, 24'h000000);
    expect_txn("b_wr02", 1, 1'b0, 1'b1, 8'h02, 24'hC2C2C2, 1'b0, 1, 1'b1, 1'b0, 24'h000000);
    @(negedge clk);
    apply_stimulus(1, 1'b1, 1'b0, 8'h00, 24'h000000);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      exp_r = (i % 2 == 1);
      exp_d = (i == 1) ? 24'hA0A0A0 : (i == 3) ? 24'hB1B1B1 : (i == 5) ? 24'hC2C2C2 : 24'h000000;
      check_output($sformatf("b_b2b_cycle%0d", i), {6'b0, b_ready, b_error, b_rdata},
                   {6'b0, exp_r, 1'b0, exp_d});
      if (i < 5) begin
        apply_stimulus(1, 1'b1, 1'b0, 8'((i + 1) / 2), 24'h000000);
      end else begin
        apply_stimulus(1, 1'b0, 1'b0, 8'h00, 24'h000000);
      end
    end

    // Depth boundary: 0x7F is the last word, 0x80 must be rejected without aliasing to 0x00.
    expect_txn("b_wr7f", 1, 1'b0, 1'b1, 8'h7F, 24'h7F7F7F, 1'b0, 1, 1'b1, 1'b0, 24'h000000);
    expect_txn("b_rd7f", 1, 1'b1, 1'b0, 8'h7F, 24'h000000, 1'b0, 1, 1'b1, 1'b0, 24'h7F7F7F);
    expect_txn("b_wr80", 1, 1'b0, 1'b1, 8'h80, 24'h999999, 1'b0, 1, 1'b0, 1'b1, 24'h000000);
    expect_txn("b_rd80", 1, 1'b1, 1'b0, 8'h80, 24'h000000, 1'b0, 1, 1'b0, 1'b1, 24'h000000);
    expect_txn("b_rd00", 1, 1'b1, 1'b0, 8'h00, 24'h000000, 1'b0, 1, 1'b1, 1'b0, 24'hA0A0A0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001: Parameter ADDR_W, default 8, address width in bits.
REQ-002: Parameter DATA_W, default 24, word width in bits.
REQ-003: Parameter DEPTH, default 256, number of implemented words; DEPTH ≤ 2**ADDR_W.
REQ-004: Parameter WAIT_CYCLES, default 2, wait states inserted per access; legal range 0..15.
REQ-005: Clock  input  1  single clock; all logic rising-edge.
REQ-006: Reset  input  1  synchronous, active-high reset.
REQ-007: MemRead  input  1  read request from the CPU datapath.
REQ-008: MemWrite  input  1  write request from the CPU datapath.
REQ-009: Address  input  ADDR_W  word address of the request.
REQ-010: WriteData  input  DATA_W  store data.
REQ-011: ReadData  output  DATA_W  load data; valid only while Ready=1.
REQ-012: Ready  output  1  one-cycle completion pulse.
REQ-013: Error  output  1  one-cycle completion pulse for a rejected request.

Function
REQ-014: The module SHALL be the responder to the CPU's MemRead/MemWrite initiator and SHALL hold a DEPTH x DATA_W word array.
REQ-015: States SHALL be IDLE, WAIT and RESP.
REQ-016: In IDLE, a request (MemRead or MemWrite high) SHALL be sampled on the clock edge.
- That edge latches Address, WriteData and the access type.
- It loads the wait counter with WAIT_CYCLES.
- It moves to WAIT, or directly to RESP when WAIT_CYCLES=0.
REQ-017: WAIT SHALL decrement the counter each cycle and move to RESP on the edge where the counter is 0.
REQ-018: Ready or Error SHALL be high for exactly the one cycle spent in RESP, first visible WAIT_CYCLES+1 edges after the sampling edge.
REQ-019: RESP SHALL always return to IDLE on the next edge.
- A request still held then is sampled as a new transaction.
- Minimum spacing is WAIT_CYCLES+2 cycles per access.
REQ-020: Request and input changes during WAIT/RESP SHALL be ignored; only latched values are used.
REQ-021: Reads SHALL drive ReadData = array[latched address] during RESP and SHALL drive zero in all other cycles.
REQ-022: A write SHALL commit the latched WriteData to the array on the edge leaving RESP, and never earlier.
REQ-023: Simultaneous MemRead and MemWrite in IDLE SHALL be handled as follows:
- The transaction completes with Error=1 and Ready=0.
- No array access occurs.
- ReadData is 0.
REQ-024: A latched address ≥ DEPTH SHALL complete with Error=1 and Ready=0, with no write and ReadData=0.
REQ-025: Ready and Error SHALL never be high in the same cycle.
REQ-026: A read to an address written by the immediately preceding transaction SHALL return the new data.

Reset
REQ-027: Reset SHALL force the following on the next edge:
- state IDLE and counter 0;
- Ready=0, Error=0, ReadData=0;
- latched address/data/type cleared.
REQ-028: Reset asserted during WAIT or RESP SHALL abort the transaction.
- No write is committed.
- No Ready/Error pulse is produced.
REQ-029: Array contents SHALL NOT be cleared by Reset.
REQ-030: Reset SHALL take priority over all requests sampled on the same edge.

Structure
REQ-031: The state enum, the default ADDR_W/DATA_W/WAIT_CYCLES values, and the 4-bit counter width SHALL live in shared package cpu_mem_pkg.
REQ-032: The wait-state down-counter SHALL be a sub-module named mem_wait_counter.
- Inputs: Clock, Reset, load, load_value.
- Output: zero flag.
REQ-033: The array SHALL be inferable as single-port synchronous RAM, with no reset on the storage.

Verification
REQ-034: Write then read, WAIT_CYCLES=2: MemWrite with Address=0x10, WriteData=0xABCDEF -> Ready pulse 3 edges after sampling; MemRead 0x10 -> ReadData=0xABCDEF with Ready.
REQ-035: WAIT_CYCLES=0: back-to-back held MemRead -> Ready on every second cycle, with ReadData matching the preloaded words.
REQ-036: Read and write together: MemRead=MemWrite=1 at Address 0x05 -> Error pulse, no Ready, and a later read of 0x05 returns the unchanged contents.
REQ-037: Out of range with DEPTH=128: MemWrite at Address 0x80 -> Error pulse; a read of 0x00 is unaffected.
REQ-038: Reset in WAIT: MemWrite 0x20 = 0x123456, Reset on the first WAIT cycle -> no Ready, and a later read of 0x20 returns the old value.
REQ-039: Input churn: change Address and WriteData every cycle during WAIT -> the write commits the values latched at the sampling edge only.
